// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared pipeline widths and defaults for the MEM stage
package mem_wb_stage_pkg;

  localparam int DEPTH_WORDS_DEF = 256;
  localparam int WORD_W          = 32;
  localparam int REG_ADDR_W      = 5;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/mem_wb_stage_data_memory.sv
// rtl/mem_wb_stage_data_memory.sv - word-addressed data RAM, sync write, sync read
// A same-edge read and write of one word returns the pre-write contents.
module data_memory
  import mem_wb_stage_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  word_t             wdata,
  output word_t             rdata
);

  word_t mem_q [DEPTH_WORDS];
  word_t rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage: branch resolve, data memory access, MEM/WB register
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic        zero_in,
  input  logic [4:0]  write_addr_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] branch_target_in,
  output logic        pc_src_out,
  output logic [31:0] branch_target_out,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic [4:0]  write_addr_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic        misaligned_out,
  output logic [31:0] wb_data_out
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  logic              misaligned;
  logic              mem_we;
  logic [ADDR_W-1:0] word_idx;
  word_t             mem_rdata;

  logic      reg_write_d,  reg_write_q;
  logic      mem_to_reg_d, mem_to_reg_q;
  reg_addr_t write_addr_d, write_addr_q;
  word_t     alu_result_d, alu_result_q;
  logic      misaligned_d, misaligned_q;
  logic      load_ok_d,    load_ok_q;

  assign pc_src_out        = branch_in & zero_in;
  assign branch_target_out = branch_target_in;

  assign misaligned = (mem_read_in | mem_write_in) & (|alu_result_in[1:0]);
  assign mem_we     = mem_write_in & ~misaligned & ~rst;
  assign word_idx   = alu_result_in[ADDR_W+1:2];

  data_memory #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_data_memory (
    .clk  (clk),
    .we   (mem_we),
    .addr (word_idx),
    .wdata(store_data_in),
    .rdata(mem_rdata)
  );

  always_comb begin
    reg_write_d  = reg_write_in & ~misaligned;
    mem_to_reg_d = mem_to_reg_in;
    write_addr_d = write_addr_in;
    alu_result_d = alu_result_in;
    misaligned_d = misaligned;
    load_ok_d    = mem_read_in & ~misaligned;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      write_addr_q <= '0;
      alu_result_q <= '0;
      misaligned_q <= 1'b0;
      load_ok_q    <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      write_addr_q <= write_addr_d;
      alu_result_q <= alu_result_d;
      misaligned_q <= misaligned_d;
      load_ok_q    <= load_ok_d;
    end
  end

  // RAM read port runs every cycle; only qualified loads are exposed
  assign read_data_out  = load_ok_q ? mem_rdata : '0;
  assign reg_write_out  = reg_write_q;
  assign mem_to_reg_out = mem_to_reg_q;
  assign write_addr_out = write_addr_q;
  assign alu_result_out = alu_result_q;
  assign misaligned_out = misaligned_q;
  assign wb_data_out    = mem_to_reg_q ? read_data_out : alu_result_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, zero_in;
  logic [4:0]  write_addr_in;
  logic [31:0] alu_result_in, store_data_in, branch_target_in;
  logic        pc_src_out;
  logic [31:0] branch_target_out;
  logic        reg_write_out, mem_to_reg_out;
  logic [4:0]  write_addr_out;
  logic [31:0] read_data_out, alu_result_out;
  logic        misaligned_out;
  logic [31:0] wb_data_out;

  int n_cmp = 0;
  int n_bad = 0;

  mem_wb_stage #(.DEPTH_WORDS(256)) dut (
    .clk              (clk),
    .rst              (rst),
    .branch_in        (branch_in),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .mem_to_reg_in    (mem_to_reg_in),
    .reg_write_in     (reg_write_in),
    .zero_in          (zero_in),
    .write_addr_in    (write_addr_in),
    .alu_result_in    (alu_result_in),
    .store_data_in    (store_data_in),
    .branch_target_in (branch_target_in),
    .pc_src_out       (pc_src_out),
    .branch_target_out(branch_target_out),
    .reg_write_out    (reg_write_out),
    .mem_to_reg_out   (mem_to_reg_out),
    .write_addr_out   (write_addr_out),
    .read_data_out    (read_data_out),
    .alu_result_out   (alu_result_out),
    .misaligned_out   (misaligned_out),
    .wb_data_out      (wb_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic mw, input logic m2r, input logic rw,
                       input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] sd);
    mem_read_in   = mr;
    mem_write_in  = mw;
    mem_to_reg_in = m2r;
    reg_write_in  = rw;
    write_addr_in = wa;
    alu_result_in = alu;
    store_data_in = sd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic rw, input logic m2r, input logic [4:0] wa,
                            input logic [31:0] rd, input logic [31:0] alu, input logic mis,
                            input logic [31:0] wb);
    check({tag, ".reg_write"},  reg_write_out,  rw);
    check({tag, ".mem_to_reg"}, mem_to_reg_out, m2r);
    check({tag, ".write_addr"}, write_addr_out, wa);
    check({tag, ".read_data"},  read_data_out,  rd);
    check({tag, ".alu_result"}, alu_result_out, alu);
    check({tag, ".misaligned"}, misaligned_out, mis);
    check({tag, ".wb_data"},    wb_data_out,    wb);
  endtask

  initial begin
    rst = 1'b1;
    branch_in = 1'b0;
    zero_in = 1'b0;
    branch_target_in = 32'h0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h0000_0020, 32'h0);
    step();
    check_regs("reset", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;

    // branch resolution is combinational and independent of rst
    branch_target_in = 32'h0040_1000;
    branch_in = 1'b1; zero_in = 1'b0; #1;
    check("br_z0", pc_src_out, 1'b0);
    zero_in = 1'b1; #1;
    check("br_z1", pc_src_out, 1'b1);
    check("br_tgt", branch_target_out, 32'h0040_1000);
    branch_in = 1'b0; #1;
    check("nobr_z1", pc_src_out, 1'b0);
    rst = 1'b1; branch_in = 1'b1; #1;
    check("br_in_rst", pc_src_out, 1'b1);
    rst = 1'b0; branch_in = 1'b0; zero_in = 1'b0;

    // store then load, back to back
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0010, 32'hDEAD_BEEF);
    step();
    check_regs("store10", 1'b0, 1'b0, 5'd0, 32'h0, 32'h10, 1'b0, 32'h10);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_0010, 32'h0);
    step();
    check_regs("load10", 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 32'h10, 1'b0, 32'hDEAD_BEEF);

    // misaligned load and store at 0x13 (same word as 0x10)
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_0013, 32'h0);
    step();
    check_regs("mis_load", 1'b0, 1'b1, 5'd4, 32'h0, 32'h13, 1'b1, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0013, 32'h5555_5555);
    step();
    check("mis_store.misaligned", misaligned_out, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h0000_0010, 32'h0);
    step();
    check("after_mis.read_data", read_data_out, 32'hDEAD_BEEF);
    check("after_mis.misaligned", misaligned_out, 1'b0);

    // read/write collision returns old data
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0010, 32'h0000_0001);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 32'h0000_0010, 32'h0000_0002);
    step();
    check("collide.read_data", read_data_out, 32'h1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h0000_0010, 32'h0);
    step();
    check("collide_next.read_data", read_data_out, 32'h2);

    // address wrap at 256 words
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0400, 32'h0000_CAFE);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_0000, 32'h0);
    step();
    check("wrap.read_data", read_data_out, 32'h0000_CAFE);
    check("wrap.wb_data", wb_data_out, 32'h0);
    check("wrap.write_addr", write_addr_out, 5'd9);

    // reset mid-stream of loads, with a store attempted under reset
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h0000_0010, 32'h0);
    step();
    check("stream.read_data", read_data_out, 32'h2);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd11, 32'h0000_0010, 32'h0000_0BAD);
    step();
    check_regs("midrst", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h0000_0010, 32'h0);
    step();
    check_regs("postrst", 1'b1, 1'b1, 5'd12, 32'h2, 32'h10, 1'b0, 32'h2);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 32'h0000_0000, 32'h0);
    step();
    check("postrst_wrap.read_data", read_data_out, 32'h0000_CAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, data-memory depth in 32-bit words (power of two).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports branch_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, zero_in  input  1 each  EX/MEM control bits.
REQ-005 SHALL have port write_addr_in  input  5  destination register number.
REQ-006 SHALL have port alu_result_in  input  32  ALU result, which is the byte address for loads and stores.
REQ-007 SHALL have port store_data_in  input  32  store data (rt value).
REQ-008 SHALL have port branch_target_in  input  32  computed branch target PC.
REQ-009 SHALL have port pc_src_out  output  1  branch taken, combinational.
REQ-010 SHALL have port branch_target_out  output  32  pass-through of branch_target_in, combinational.
REQ-011 SHALL have ports reg_write_out, mem_to_reg_out  output  1 each  registered MEM/WB control bits.
REQ-012 SHALL have port write_addr_out  output  5  registered destination register.
REQ-013 SHALL have ports read_data_out, alu_result_out  output  32 each  registered load data and ALU result.
REQ-014 SHALL have port misaligned_out  output  1  registered misaligned-access flag.
REQ-015 SHALL have port wb_data_out  output  32  writeback value, combinational from registered state.

Function
REQ-016 pc_src_out SHALL equal branch_in AND zero_in, with zero latency and independent of rst.
REQ-017 Word index SHALL be alu_result_in[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored (wrap-around aliasing).
REQ-018 An access SHALL be misaligned when (mem_read_in OR mem_write_in) AND alu_result_in[1:0] != 0.
REQ-019 A store SHALL write store_data_in to the indexed word at the clk edge when mem_write_in=1, not misaligned, and rst=0.
REQ-020 A misaligned store SHALL NOT modify memory.
REQ-021 A load SHALL register the indexed word into read_data_out at the clk edge, giving 1-cycle latency from the EX/MEM inputs to MEM/WB outputs.
REQ-022 When mem_read_in=0 or the load is misaligned, read_data_out SHALL be 0 in the next cycle.
REQ-023 When mem_read_in=1 and mem_write_in=1 to the same word, the store SHALL complete and read_data_out SHALL return the old (pre-write) contents.
REQ-024 At each edge, reg_write_out SHALL take reg_write_in AND NOT misaligned, suppressing writeback of faulting accesses.
REQ-025 mem_to_reg_out, write_addr_out, and alu_result_out SHALL register their inputs unchanged at each edge.
REQ-026 misaligned_out SHALL be high for exactly the cycle following a misaligned access.
REQ-027 wb_data_out SHALL be read_data_out when mem_to_reg_out=1, else alu_result_out.
REQ-028 Back-to-back accesses SHALL be accepted every cycle with no stall or bubble.

Reset
REQ-029 When rst=1 at an edge, all registered outputs SHALL be cleared to 0, and wb_data_out therefore to 0.
REQ-030 Memory contents SHALL be unaffected by rst, and stores SHALL be suppressed in any cycle where rst=1.
REQ-031 Asserting rst mid-stream SHALL discard the in-flight MEM/WB entry; the first post-reset edge SHALL capture fresh inputs.

Structure
REQ-032 The shared pipeline package SHALL hold DEPTH_WORDS default, word width 32, and register-address width 5.
REQ-033 The data memory SHALL be one sub-module, data_memory (synchronous write, synchronous read, old-data-on-collision); the MEM/WB register and branch logic SHALL live in mem_wb_stage.

Verification
REQ-034 Scenario: store 0xDEADBEEF at addr 0x10, then load addr 0x10 with mem_to_reg=1 -> next cycle read_data_out = 0xDEADBEEF and wb_data_out = 0xDEADBEEF.
REQ-035 Scenario: branch_in=1 with zero_in toggled 0/1 -> pc_src_out follows zero_in in the same cycle, and branch_target_out = branch_target_in.
REQ-036 Scenario: load at addr 0x13 with reg_write=1 -> misaligned_out=1, reg_write_out=0, read_data_out=0; a store at 0x13 leaves the word unchanged.
REQ-037 Scenario: word 4 = 0x1 and a simultaneous read+write of 0x2 to addr 0x10 -> read_data_out = 0x1; a following load -> 0x2.
REQ-038 Scenario: with DEPTH_WORDS=256, a store to 0x400 then a load from 0x000 -> same data (wrap).
REQ-039 Scenario: rst asserted during a stream of loads -> all registered outputs 0 at the next edge while memory contents are retained.
